// File: rtl/beat_gate_pkg.sv
// Shared types, constants and helpers for the beat gating controller.
package beat_gate_pkg;

  typedef enum logic [0:0] {ST_CAL, ST_RUN} beat_gate_state_t;

  localparam int unsigned BEAT_CNT_W = 16;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/beat_gate_channel.sv
// One measurement channel: qualifies samples, gates them into single beats
// per loud burst, stretches each beat for the LED and counts beats.
module beat_gate_channel
  import beat_gate_pkg::*;
#(
  parameter int unsigned W           = 16,
  parameter int unsigned SNR_THRESH  = 25,
  parameter int unsigned RMS_FLOOR   = 100,
  parameter int unsigned HOLDOFF_CYC = 200,
  parameter int unsigned PULSE_CYC   = 50
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  recal,
  input  logic                  clear,
  input  logic                  meas_valid,
  input  logic [W-1:0]          snr_db,
  input  logic [W-1:0]          signal_rms,
  output logic                  beat_pulse,
  output logic                  beat_led,
  output logic [BEAT_CNT_W-1:0] beat_count
);

  localparam int unsigned HO_W  = $clog2(HOLDOFF_CYC + 1);
  localparam int unsigned LED_W = $clog2(PULSE_CYC + 1);

  logic                  qualify;
  logic                  beat;
  logic                  armed;
  logic [HO_W-1:0]       holdoff;
  logic [LED_W-1:0]      led_cnt;
  logic [BEAT_CNT_W-1:0] beat_cnt;

  assign qualify = meas_valid && (snr_db >= W'(SNR_THRESH)) && (signal_rms > W'(RMS_FLOOR));
  // recal takes priority so a beat never lands on the cycle calibration restarts
  assign beat    = run && qualify && armed && (holdoff == '0) && !recal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_pulse <= 1'b0;
      armed      <= 1'b1;
      holdoff    <= '0;
      led_cnt    <= '0;
      beat_cnt   <= '0;
    end else if (clear) begin
      beat_pulse <= 1'b0;
      armed      <= 1'b1;
      holdoff    <= '0;
      led_cnt    <= '0;
      beat_cnt   <= '0;
    end else begin
      beat_pulse <= beat;
      if (beat) begin
        armed   <= 1'b0;
        holdoff <= HO_W'(HOLDOFF_CYC);
        led_cnt <= LED_W'(PULSE_CYC);
        if (beat_cnt != '1) beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
      end else begin
        if (run && meas_valid && !qualify) armed <= 1'b1;
        if (holdoff != '0) holdoff <= holdoff - HO_W'(1);
        if (led_cnt != '0) led_cnt <= led_cnt - LED_W'(1);
      end
    end
  end

  assign beat_led   = run && (led_cnt != '0);
  assign beat_count = beat_cnt;

endmodule

// File: rtl/beat_gate_ctrl.sv
// Calibration sequencer and per-channel beat gating for the LED/video consumers.
//   state  | meaning
//   ST_CAL | quiet period for the SNR front end, measurements ignored
//   ST_RUN | measurements qualified into beats
module beat_gate_ctrl
  import beat_gate_pkg::*;
#(
  parameter int unsigned W          = 16,
  parameter int unsigned N_CH       = 2,
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned CAL_MS     = 1000,
  parameter int unsigned SNR_THRESH = 25,
  parameter int unsigned RMS_FLOOR  = 100,
  parameter int unsigned HOLDOFF_MS = 200,
  parameter int unsigned PULSE_MS   = 50
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         recal_req,
  input  logic [N_CH*W-1:0]            snr_db,
  input  logic [N_CH*W-1:0]            signal_rms,
  input  logic [N_CH-1:0]              meas_valid,
  output logic                         quiet_period,
  output logic                         calibration_done,
  output logic [N_CH-1:0]              beat_pulse,
  output logic [N_CH-1:0]              beat_led,
  output logic [N_CH*BEAT_CNT_W-1:0]   beat_count
);

  localparam int unsigned CAL_CYC     = ms_to_cycles(CLK_HZ, CAL_MS);
  localparam int unsigned HOLDOFF_CYC = ms_to_cycles(CLK_HZ, HOLDOFF_MS);
  localparam int unsigned PULSE_CYC   = ms_to_cycles(CLK_HZ, PULSE_MS);
  localparam int unsigned CAL_W       = $clog2(CAL_CYC + 1);

  beat_gate_state_t state, state_nxt;
  logic [CAL_W-1:0] cal_cnt;
  logic             cal_last;
  logic             cal_exit;
  logic             run;

  assign cal_last = (cal_cnt == CAL_W'(CAL_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_CAL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CAL:  if (!recal_req && cal_last) state_nxt = ST_RUN;
      ST_RUN:  if (recal_req) state_nxt = ST_CAL;
      default: state_nxt = ST_CAL;
    endcase
  end

  always_comb begin
    quiet_period = 1'b0;
    run          = 1'b0;
    cal_exit     = 1'b0;
    case (state)
      ST_CAL: begin
        quiet_period = 1'b1;
        cal_exit     = !recal_req && cal_last;
      end
      ST_RUN:  run = 1'b1;
      default: ;
    endcase
  end

  // counter idles at zero in RUN so a recal always starts a full quiet period
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cal_cnt <= '0;
    end else if (recal_req || (state != ST_CAL) || cal_last) begin
      cal_cnt <= '0;
    end else begin
      cal_cnt <= cal_cnt + CAL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         calibration_done <= 1'b0;
    else if (cal_exit) calibration_done <= 1'b1;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    beat_gate_channel #(
      .W          (W),
      .SNR_THRESH (SNR_THRESH),
      .RMS_FLOOR  (RMS_FLOOR),
      .HOLDOFF_CYC(HOLDOFF_CYC),
      .PULSE_CYC  (PULSE_CYC)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .recal      (recal_req),
      .clear      (cal_exit),
      .meas_valid (meas_valid[i]),
      .snr_db     (snr_db[i*W +: W]),
      .signal_rms (signal_rms[i*W +: W]),
      .beat_pulse (beat_pulse[i]),
      .beat_led   (beat_led[i]),
      .beat_count (beat_count[i*BEAT_CNT_W +: BEAT_CNT_W])
    );
  end

endmodule
